// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: 16 one-word lines between CPU fetch and instruction memory.
// Latency: hit is combinational (0 cycles); miss stalls 2 cycles and forwards the word in the 3rd (FILL).
// Backpressure: IC_stall holds the fetch stage during miss-detect and REQ; cpu inputs are ignored until FILL.
module icache_dm #(
    parameter int bit_size = 32,
    parameter int mem_size = 16,
    parameter int LINES    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [mem_size-1:0] cpu_addr,
    input  logic                cpu_req,
    input  logic                flush,
    output logic [bit_size-1:0] cpu_instr,
    output logic                IC_stall,
    output logic [mem_size-1:0] IM_Address,
    output logic                IM_en_Read,
    input  logic [bit_size-1:0] Instruction,
    output logic [15:0]         hit_cnt,
    output logic [15:0]         miss_cnt
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = mem_size - 2 - IDX_W;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t                state_q, state_d;
    logic [mem_size-1:0]   miss_addr_q, miss_addr_d;
    logic [15:0]           hit_cnt_q, hit_cnt_d;
    logic [15:0]           miss_cnt_q, miss_cnt_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [bit_size-1:0]   data_q [LINES];

    logic [IDX_W-1:0]      idx, fill_idx;
    logic [TAG_W-1:0]      tag, fill_tag;
    logic                  hit;
    logic                  fill_we;
    logic [bit_size-1:0]   instr_c;
    logic                  stall_c;
    logic                  rd_en_c;
    logic [mem_size-1:0]   im_addr_c;

    assign idx      = cpu_addr[IDX_W+1:2];
    assign tag      = cpu_addr[mem_size-1:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W+1:2];
    assign fill_tag = miss_addr_q[mem_size-1:IDX_W+2];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);

    // Next-state, counters, valid bits and fetch-side outputs.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        valid_d     = valid_q;
        fill_we     = 1'b0;
        instr_c     = '0;
        stall_c     = 1'b0;
        rd_en_c     = 1'b0;
        im_addr_c   = cpu_addr;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (hit) begin
                        instr_c = data_q[idx];
                        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
                    end else begin
                        stall_c     = 1'b1;
                        miss_addr_d = cpu_addr;
                        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                im_addr_c = miss_addr_q;
                rd_en_c   = 1'b1;
                stall_c   = 1'b1;
                state_d   = FILL;
            end
            FILL: begin
                im_addr_c         = miss_addr_q;
                instr_c           = Instruction;
                fill_we           = 1'b1;
                valid_d[fill_idx] = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over a same-cycle fill: the line is written but left invalid.
        if (flush) valid_d = '0;
    end

    // Control state; an in-flight miss is abandoned on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            valid_q     <= valid_d;
        end
    end

    // Tag/data arrays carry no reset; valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= Instruction;
        end
    end

    // Fetch-side outputs are forced quiet while reset is asserted.
    assign cpu_instr  = rst ? '0 : instr_c;
    assign IC_stall   = rst ? 1'b0 : stall_c;
    assign IM_en_Read = rst ? 1'b0 : rd_en_c;
    assign IM_Address = im_addr_c;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_icache_dm.sv
// Testbench for icache_dm: IM model, reference cache model and expectation queue.
// Each fetch pushes its expected word and stall count; the test pops and compares.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic        cpu_req = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] cpu_instr;
    logic        IC_stall;
    logic [15:0] IM_Address;
    logic        IM_en_Read;
    logic [31:0] Instruction = '0;
    logic [15:0] hit_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        int          stalls;
    } exp_t;
    exp_t exp_q[$];

    logic        m_valid [16];
    logic [9:0]  m_tag   [16];
    logic [15:0] exp_hits, exp_miss;

    icache_dm dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_req    (cpu_req),
        .flush      (flush),
        .cpu_instr  (cpu_instr),
        .IC_stall   (IC_stall),
        .IM_Address (IM_Address),
        .IM_en_Read (IM_en_Read),
        .Instruction(Instruction),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] im_word(input logic [15:0] a);
        if (a == 16'h0000) return 32'h20080005;
        return {~a, a};
    endfunction

    // Instruction memory: data valid the cycle after a sampled read enable.
    always @(posedge clk) if (IM_en_Read) Instruction <= im_word(IM_Address);

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        exp_hits = '0;
        exp_miss = '0;
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void model_fetch(input logic [15:0] a, input bit flush_fill);
        logic [3:0] ix;
        logic       h;
        exp_t       e;
        ix = a[5:2];
        h  = m_valid[ix] && (m_tag[ix] == a[15:6]);
        e.instr  = im_word(a);
        e.stalls = h ? 0 : 2;
        exp_q.push_back(e);
        if (h) begin
            if (exp_hits != 16'hFFFF) exp_hits = exp_hits + 16'd1;
        end else begin
            if (exp_miss != 16'hFFFF) exp_miss = exp_miss + 16'd1;
            m_tag[ix]   = a[15:6];
            m_valid[ix] = 1'b1;
            if (flush_fill) model_flush();
        end
    endfunction

    // Drives one fetch until the word is delivered; returns to posedge+1 afterwards.
    task automatic fetch(input logic [15:0] a, input bit flush_fill,
                         output logic [31:0] instr, output int stalls,
                         output int reads, output logic [15:0] rd_addr);
        bit done;
        done    = 1'b0;
        stalls  = 0;
        reads   = 0;
        rd_addr = 'x;
        instr   = 'x;
        model_fetch(a, flush_fill);
        cpu_req  = 1'b1;
        cpu_addr = a;
        for (int c = 0; c < 10 && !done; c++) begin
            if (flush_fill && c == 2) flush = 1'b1;
            @(negedge clk);
            if (IM_en_Read) begin
                reads++;
                rd_addr = IM_Address;
            end
            if (!IC_stall) begin
                instr = cpu_instr;
                done  = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
            flush = 1'b0;
        end
        if (!done) stalls = 99;
    endtask

    task automatic apply_reset();
        cpu_req = 1'b0;
        flush   = 1'b0;
        rst     = 1'b1;
        #7;
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        cpu_req = 1'b0;
        flush   = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        model_flush();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_addr = 16'h1234;
        #3;
        checks++;
        if (IC_stall !== 1'b0 || IM_en_Read !== 1'b0 || cpu_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b rd=%b instr=%h, required 0/0/0", IC_stall, IM_en_Read, cpu_instr);
        end
        apply_reset();
        @(negedge clk);
        checks++;
        if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_counters: hit=%h miss=%h, required 0/0", hit_cnt, miss_cnt);
        end
        checks++;
        if (IM_Address !== 16'h1234 || IM_en_Read !== 1'b0 || IC_stall !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: addr=%h rd=%b stall=%b, required 1234/0/0", IM_Address, IM_en_Read, IC_stall);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_cold_miss();
        logic [31:0] instr;
        logic [15:0] ra;
        int st, rd;
        exp_t e;
        fetch(16'h0000, 1'b0, instr, st, rd, ra);
        e = exp_q.pop_front();
        checks++;
        if (instr !== 32'h20080005 || instr !== e.instr || st !== 2) begin
            errors++;
            $display("FAIL cold_miss: instr=%h stalls=%0d, required 20080005/2", instr, st);
        end
        checks++;
        if (rd !== 1 || ra !== 16'h0000) begin
            errors++;
            $display("FAIL cold_im_read: reads=%0d addr=%h, required 1/0000", rd, ra);
        end
        fetch(16'h0000, 1'b0, instr, st, rd, ra);
        e = exp_q.pop_front();
        checks++;
        if (instr !== e.instr || st !== e.stalls || rd !== 0) begin
            errors++;
            $display("FAIL cold_rehit: instr=%h stalls=%0d reads=%0d, required %h/%0d/0", instr, st, rd, e.instr, e.stalls);
        end
        checks++;
        if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
            errors++;
            $display("FAIL cold_counters: hit=%0d miss=%0d, required 1/1", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_conflict();
        logic [15:0] seq [3];
        logic [31:0] instr;
        logic [15:0] ra;
        int st, rd;
        exp_t e;
        seq[0] = 16'h0004;
        seq[1] = 16'h0044;
        seq[2] = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            fetch(seq[i], 1'b0, instr, st, rd, ra);
            e = exp_q.pop_front();
            checks++;
            if (instr !== e.instr || st !== e.stalls || st !== 2) begin
                errors++;
                $display("FAIL conflict_%0d: instr=%h stalls=%0d, required %h/2", i, instr, st, e.instr);
            end
        end
        checks++;
        if (hit_cnt !== exp_hits || miss_cnt !== exp_miss) begin
            errors++;
            $display("FAIL conflict_counters: hit=%0d miss=%0d, required %0d/%0d", hit_cnt, miss_cnt, exp_hits, exp_miss);
        end
    endtask

    task automatic test_flush();
        logic [31:0] instr;
        logic [15:0] ra;
        int st, rd;
        exp_t e;
        fetch(16'h0008, 1'b0, instr, st, rd, ra);
        e = exp_q.pop_front();
        fetch(16'h0008, 1'b0, instr, st, rd, ra);
        e = exp_q.pop_front();
        checks++;
        if (st !== 0 || instr !== e.instr) begin
            errors++;
            $display("FAIL flush_precached: stalls=%0d instr=%h, required 0/%h", st, instr, e.instr);
        end
        pulse_flush();
        fetch(16'h0008, 1'b0, instr, st, rd, ra);
        e = exp_q.pop_front();
        checks++;
        if (st !== 2 || st !== e.stalls || instr !== e.instr) begin
            errors++;
            $display("FAIL flush_refetch: stalls=%0d instr=%h, required 2/%h", st, instr, e.instr);
        end
        fetch(16'h000C, 1'b1, instr, st, rd, ra);
        e = exp_q.pop_front();
        checks++;
        if (instr !== e.instr || st !== e.stalls) begin
            errors++;
            $display("FAIL flush_in_fill_fwd: instr=%h stalls=%0d, required %h/%0d", instr, st, e.instr, e.stalls);
        end
        fetch(16'h000C, 1'b0, instr, st, rd, ra);
        e = exp_q.pop_front();
        checks++;
        if (st !== 2 || st !== e.stalls || instr !== e.instr) begin
            errors++;
            $display("FAIL flush_in_fill_refetch: stalls=%0d instr=%h, required 2/%h", st, instr, e.instr);
        end
        checks++;
        if (hit_cnt !== exp_hits || miss_cnt !== exp_miss) begin
            errors++;
            $display("FAIL flush_counters: hit=%0d miss=%0d, required %0d/%0d", hit_cnt, miss_cnt, exp_hits, exp_miss);
        end
    endtask

    task automatic test_loop();
        logic [31:0] instr;
        logic [15:0] ra;
        int st, rd, total, bad;
        exp_t e;
        apply_reset();
        total = 0;
        bad   = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 16; i++) begin
                fetch(16'(i * 4), 1'b0, instr, st, rd, ra);
                e = exp_q.pop_front();
                total += st;
                checks++;
                if (instr !== e.instr || st !== e.stalls) begin
                    errors++;
                    $display("FAIL loop_p%0d_%0d: instr=%h stalls=%0d, required %h/%0d", pass, i, instr, st, e.instr, e.stalls);
                end
            end
        end
        checks++;
        if (total !== 32) begin
            errors++;
            $display("FAIL loop_stall_total: got %0d, required 32", total);
        end
        checks++;
        if (hit_cnt !== 16'd16 || miss_cnt !== 16'd16) begin
            errors++;
            $display("FAIL loop_counters: hit=%0d miss=%0d, required 16/16", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_reset_mid_miss();
        logic [31:0] instr;
        logic [15:0] ra;
        int st, rd;
        exp_t e;
        cpu_req  = 1'b1;
        cpu_addr = 16'h0100;
        @(posedge clk);
        #1;
        checks++;
        if (IM_en_Read !== 1'b1 || IC_stall !== 1'b1 || IM_Address !== 16'h0100) begin
            errors++;
            $display("FAIL mid_miss_req: rd=%b stall=%b addr=%h, required 1/1/0100", IM_en_Read, IC_stall, IM_Address);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (IM_en_Read !== 1'b0 || IC_stall !== 1'b0 || cpu_instr !== 32'h0) begin
            errors++;
            $display("FAIL mid_miss_async: rd=%b stall=%b instr=%h, required 0/0/0", IM_en_Read, IC_stall, cpu_instr);
        end
        checks++;
        if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
            errors++;
            $display("FAIL mid_miss_counters: hit=%h miss=%h, required 0/0", hit_cnt, miss_cnt);
        end
        @(negedge clk);
        cpu_req = 1'b0;
        rst     = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        fetch(16'h0100, 1'b0, instr, st, rd, ra);
        e = exp_q.pop_front();
        checks++;
        if (st !== 2 || st !== e.stalls || instr !== e.instr) begin
            errors++;
            $display("FAIL mid_miss_refetch: stalls=%0d instr=%h, required 2/%h", st, instr, e.instr);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] start_hits;
        logic [31:0] sum;
        start_hits = hit_cnt;
        cpu_req  = 1'b1;
        cpu_addr = 16'h0100;
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (hit_cnt !== start_hits + 16'd100) begin
            errors++;
            $display("FAIL sat_partial: hit=%0d, required %0d", hit_cnt, start_hits + 16'd100);
        end
        checks++;
        if (cpu_instr !== im_word(16'h0100) || IC_stall !== 1'b0) begin
            errors++;
            $display("FAIL sat_hit_data: instr=%h stall=%b, required %h/0", cpu_instr, IC_stall, im_word(16'h0100));
        end
        repeat (65440) @(posedge clk);
        #1;
        cpu_req = 1'b0;
        sum = 32'(start_hits) + 32'd65540;
        exp_hits = (sum > 32'h0000FFFF) ? 16'hFFFF : sum[15:0];
        checks++;
        if (hit_cnt !== 16'hFFFF || hit_cnt !== exp_hits) begin
            errors++;
            $display("FAIL sat_hit_cnt: hit=%h, required FFFF", hit_cnt);
        end
        checks++;
        if (miss_cnt !== exp_miss) begin
            errors++;
            $display("FAIL sat_miss_cnt: miss=%0d, required %0d", miss_cnt, exp_miss);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cold_miss();
        test_conflict();
        test_flush();
        test_loop();
        test_reset_mid_miss();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
